gate_sweep_checker: RTL
=======================

Name: gate_sweep_checker

Overview:
- Parametrised successor to the fixed 3-input NAND exhaustive bench: a synthesizable sweep engine for an N-input gate under test (GUT).
- Drives every input pattern 0..2^N-1 in ascending order and holds each one for DWELL cycles.
- Samples the GUT's 1-bit response at the end of each dwell and compares it against a selectable reference function (AND/NAND/OR/NOR/XOR/XNOR).
- Reports pass/fail, an error count and the first failing pattern; it sits beside the GUT in on-board lab self-test tops.

Parameters:
- N_INPUTS, 3, GUT input count; legal range 1..16.
- DWELL, 20, cycles each pattern is held; legal minimum 2.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- mode  in  3  reference function: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 reserved, treated as NAND.
- pattern_out  out  N_INPUTS  stimulus to the GUT.
- gut_out  in  1  GUT response.
- busy  out  1  high while sweeping.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- fail_valid  out  1  at least one mismatch recorded this run.
- fail_pattern  out  N_INPUTS  pattern of the first mismatch.

Behaviour:
- Reset: the block enters IDLE. All outputs are 0: pattern_out, busy, done, pass, err_count, fail_valid and fail_pattern. Reset mid-sweep aborts the run immediately and discards its results.
- States: IDLE, APPLY, DONE.
- IDLE/DONE + start:
  - mode is latched into an internal register for the whole run; later changes to mode are ignored.
  - err_count, fail_valid and fail_pattern are cleared.
  - pattern_out is set to 0, the dwell counter to 0, and the state moves to APPLY.
  - busy=1 and done=0 from the next cycle.
- APPLY: the dwell counter increments every cycle. On the cycle with counter==DWELL-1 (the sample cycle):
  - gut_out is compared with ref(latched mode, pattern_out).
  - On mismatch, err_count increments with saturation. If fail_valid==0, fail_pattern<=pattern_out and fail_valid<=1.
  - If pattern_out==all-ones, the next state is DONE. Otherwise pattern_out increments and the counter returns to 0.
- DONE: busy=0 and done=1. pattern_out holds its last value (all-ones), so the GUT stays driven.
- Latency: if start is sampled at cycle t, pattern k is applied over cycles t+1+k*DWELL .. t+(k+1)*DWELL, and done rises at t+1+2^N*DWELL. For N=3 and DWELL=20, done rises at t+161.
- start while busy is ignored; it does not restart the sweep.
- start in the same cycle as rst: rst wins.
- Reference functions are reductions over all N bits of pattern_out. XOR is odd parity.
- Counter widths are sized with $clog2(DWELL). Pattern wrap is never reached, because the sweep stops at all-ones.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves the block to DONE at the end of that sample cycle. pattern_out freezes at the failing pattern, err_count==1 and pass==0.
- Undefined: the full sweep always completes and every mismatch is counted.

Decomposition:
- Package gate_sweep_pkg holds:
  - the mode encodings (MODE_AND..MODE_XNOR);
  - the state encoding (ST_IDLE, ST_APPLY, ST_DONE).
- Sub-module gate_ref_model is natural. It is combinational, parametrised by N_INPUTS, takes mode and pattern, and outputs the expected bit. Benches reuse it as their golden model.

Test Plan:
- Correct NAND: N=3, DWELL=20, mode=1, GUT=real 3-input NAND, start at t -> done at t+161, pass=1, err_count=0, fail_valid=0.
- Stuck-at-1 GUT: N=3, mode=1, gut_out tied 1 -> err_count=1, fail_pattern=3'b111, pass=0.
- Mode sweep: N=4, DWELL=2, GUT=XOR, run mode=4 then mode=5 -> first run pass=1; second run err_count=16, fail_pattern=0.
- Mode and start during a sweep: N=3, change mode and pulse start mid-sweep -> sweep is unaffected; results match the latched mode and done still rises at t+161.
- Reset at pattern 5: N=3, assert rst -> next cycle all outputs are 0 and the state is IDLE; a fresh start completes normally.
- Saturation and stop-on-fail: N=4, ERR_W=3, gut_out tied 0 with mode=1 -> err_count saturates at 7. With GATE_SWEEP_STOP_ON_FAIL_EN defined, the same stimulus gives done after the first sample (t+1+DWELL), err_count=1 and pattern_out=0.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared encodings for the gate sweep checker.
//   mode_e  - reference function select (MODE_AND..MODE_XNOR; codes 6/7 reserved)
//   state_e - sweep controller states (ST_IDLE, ST_APPLY, ST_DONE)
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_NAND = 3'd1,
    MODE_OR   = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational reference for an N-input reduction gate.
//   mode     in  3         function select (AND/NAND/OR/NOR/XOR/XNOR; 6,7 -> NAND)
//   pattern  in  N_INPUTS  gate inputs
//   expected out 1         reference output for pattern under mode
module gate_ref_model #(
  parameter int unsigned N_INPUTS = 3
) (
  input  logic [2:0]          mode,
  input  logic [N_INPUTS-1:0] pattern,
  output logic                expected
);
  import gate_sweep_pkg::*;

  always_comb begin
    expected = ~&pattern;
    case (mode)
      MODE_AND:  expected = &pattern;
      MODE_NAND: expected = ~&pattern;
      MODE_OR:   expected = |pattern;
      MODE_NOR:  expected = ~|pattern;
      MODE_XOR:  expected = ^pattern;
      MODE_XNOR: expected = ~^pattern;
      default:   expected = ~&pattern;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive sweep engine for an N-input gate under test.
// Applies patterns 0..2^N-1 in order, each held DWELL cycles, samples gut_out on
// the last dwell cycle and compares it with the reference selected by mode
// (latched at start).
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse, honoured in IDLE or DONE only
//   mode[2:0]     reference function select
//   pattern_out   stimulus to the GUT
//   gut_out       GUT response
//   busy, done    sweeping / finished (done held until next start or rst)
//   pass          done with zero mismatches
//   err_count     saturating mismatch count
//   fail_valid    a mismatch was recorded this run
//   fail_pattern  first mismatching pattern
// Build option: GATE_SWEEP_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_sweep_checker #(
  parameter int unsigned N_INPUTS = 3,
  parameter int unsigned DWELL    = 20,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          mode,
  output logic [N_INPUTS-1:0] pattern_out,
  input  logic                gut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_pattern
);
  import gate_sweep_pkg::*;

  localparam int unsigned         CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_q;
  logic             expected;
  logic             launch;
  logic             sample;
  logic             mismatch;

  gate_ref_model #(.N_INPUTS(N_INPUTS)) u_ref (
    .mode     (mode_q),
    .pattern  (pattern_out),
    .expected (expected)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    sample   = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          sample   = 1'b1;
          mismatch = (gut_out != expected);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
          if (mismatch || (&pattern_out)) state_d = ST_DONE;
`else
          if (&pattern_out) state_d = ST_DONE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= '0;
      pattern_out  <= '0;
      cnt_q        <= '0;
      err_count    <= '0;
      fail_valid   <= 1'b0;
      fail_pattern <= '0;
    end else if (launch) begin
      mode_q       <= mode;
      pattern_out  <= '0;
      cnt_q        <= '0;
      err_count    <= '0;
      fail_valid   <= 1'b0;
      fail_pattern <= '0;
    end else if (sample) begin
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (!fail_valid) begin
          fail_valid   <= 1'b1;
          fail_pattern <= pattern_out;
        end
      end
      // pattern_out only advances while staying in APPLY, so it freezes on the
      // final (or, with stop-on-fail, the failing) pattern in DONE.
      if (state_d == ST_APPLY) begin
        pattern_out <= pattern_out + N_INPUTS'(1);
        cnt_q       <= '0;
      end
    end else if (state_q == ST_APPLY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign busy = (state_q == ST_APPLY);
  assign done = (state_q == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule
